// File: rtl/drum_pipe.sv
// drum_pipe: 3-stage pipelined signed DRUM / exact multiplier
// with valid/ready handshake and full back-pressure.
module drum_pipe #(
  parameter int K = 6,
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_exact,
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] r,
  output logic           out_exact
);

  localparam int W  = (N > M) ? N : M;
  localparam int SW = $clog2(W + 1);
  localparam int L  = N + M;

  // Shift that puts the leading one at bit K-1.
  // Zero when the value already fits in K bits.
  function automatic logic [SW-1:0] f_sh(
    input logic [W-1:0] x
  );
    logic [SW-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++)
      if (x[i]) p = SW'(i);
    if ((x >> K) == '0) return '0;
    return p - SW'(K - 1);
  endfunction

  // Truncated K-bit mantissa.
  // The lsb is forced high once bits were dropped.
  function automatic logic [K-1:0] f_tr(
    input logic [W-1:0]  x,
    input logic [SW-1:0] sh
  );
    logic [W-1:0] y;
    y = x >> sh;
    if (sh == '0) return y[K-1:0];
    return y[K-1:0] | K'(1);
  endfunction

  logic         w_en;
  logic         r_v1, r_e1, r_s1;
  logic [N-1:0] r_x1;
  logic [M-1:0] r_y1;
  logic         r_v2, r_e2, r_s2;
  logic [N-1:0] r_x2;
  logic [M-1:0] r_y2;
  logic [SW-1:0] r_shx2, r_shy2;
  logic         r_v3, r_e3;
  logic [L-1:0] r_r3;

  logic [W-1:0]  w_xz, w_yz;
  logic [SW-1:0] w_shx, w_shy;
  logic [K-1:0]  w_tx, w_ty;

  logic [2*K-1:0]       w_tt;
  logic [SW:0]          w_sh;
  logic [L-1:0]         w_p;
  logic signed [L-1:0]  w_ea, w_eb, w_ex;
  logic [L-1:0]         w_res;

  assign w_en      = !r_v3 | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v3;
  assign out_exact = r_e3;
  assign r         = r_r3;

  // Stage 1: sign and one's-complement magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_e1 <= 1'b0;
      r_s1 <= 1'b0;
      r_x1 <= '0;
      r_y1 <= '0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      r_e1 <= in_exact;
      r_s1 <= a[N-1] ^ b[M-1];
      r_x1 <= (!in_exact && a[N-1]) ? ~a : a;
      r_y1 <= (!in_exact && b[M-1]) ? ~b : b;
    end
  end

  assign w_xz  = W'(r_x1);
  assign w_yz  = W'(r_y1);
  assign w_shx = f_sh(w_xz);
  assign w_shy = f_sh(w_yz);
  assign w_tx  = f_tr(w_xz, w_shx);
  assign w_ty  = f_tr(w_yz, w_shy);

  // Stage 2: DRUM truncation, exact beats pass through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_e2   <= 1'b0;
      r_s2   <= 1'b0;
      r_x2   <= '0;
      r_y2   <= '0;
      r_shx2 <= '0;
      r_shy2 <= '0;
    end else if (w_en) begin
      r_v2   <= r_v1;
      r_e2   <= r_e1;
      r_s2   <= r_s1;
      r_x2   <= r_e1 ? r_x1 : N'(w_tx);
      r_y2   <= r_e1 ? r_y1 : M'(w_ty);
      r_shx2 <= r_e1 ? '0 : w_shx;
      r_shy2 <= r_e1 ? '0 : w_shy;
    end
  end

  assign w_tt  = (2*K)'(r_x2[K-1:0])
               * (2*K)'(r_y2[K-1:0]);
  assign w_sh  = {1'b0, r_shx2} + {1'b0, r_shy2};
  assign w_p   = L'(w_tt) << w_sh;
  assign w_ea  = L'($signed(r_x2));
  assign w_eb  = L'($signed(r_y2));
  assign w_ex  = w_ea * w_eb;
  assign w_res = r_e2 ? w_ex
               : (r_s2 ? ~w_p : w_p);

  // Stage 3: multiply, restore sign, hold under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3 <= 1'b0;
      r_e3 <= 1'b0;
      r_r3 <= '0;
    end else if (w_en) begin
      r_v3 <= r_v2;
      r_e3 <= r_e2;
      r_r3 <= w_res;
    end
  end

endmodule

// File: tb/tb_drum_pipe.sv
// tb_drum_pipe: scoreboard bench for drum_pipe
// (K=6, N=16, M=16).
module tb_drum_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_exact;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r;
  logic        out_exact;

  int n_run  = 0;
  int n_fail = 0;
  logic [32:0] q[$];

  always #5 clk = ~clk;

  drum_pipe #(.K(6), .N(16), .M(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_exact(in_exact),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r(r),
    .out_exact(out_exact)
  );

  // Reference: returns {mode, result}
  function automatic logic [32:0] f_model(
    input logic [15:0] ia,
    input logic [15:0] ib,
    input logic        ie
  );
    longint sa, sb, ma, mb, ta, tb, p;
    int sha, shb;
    logic s;
    logic [31:0] pr;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    if (ie) return {1'b1, 32'(sa * sb)};
    s  = (sa < 0) ^ (sb < 0);
    ma = (sa < 0) ? -sa - 1 : sa;
    mb = (sb < 0) ? -sb - 1 : sb;
    ta = ma; sha = 0;
    while (ta >= 64) begin ta = ta >> 1; sha++; end
    if (sha > 0) ta = ta | 1;
    tb = mb; shb = 0;
    while (tb >= 64) begin tb = tb >> 1; shb++; end
    if (shb > 0) tb = tb | 1;
    p  = (ta * tb) << (sha + shb);
    pr = 32'(p);
    return {1'b0, s ? ~pr : pr};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_exact = 1'b0;
    a = '0; b = '0; out_ready = 1'b1;
    #12;
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0", out_valid);
    end
    n_run++;
    if (r !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_r got %h want 0", r);
    end
    n_run++;
    if (out_exact !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_exact got %b want 0", out_exact);
    end
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    int found;
    found = -1;
    a = 16'd1000; b = 16'd3; in_exact = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid && found < 0) begin
        found = c;
        n_run++;
        if ({out_exact, r} !== {1'b0, 32'd3024}) begin
          n_fail++;
          $display("FAIL latency_val got %b/%h want 0/%h",
                   out_exact, r, 32'd3024);
        end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    n_run++;
    if (found !== 3) begin
      n_fail++;
      $display("FAIL latency got %0d want 3", found);
    end
  endtask

  task automatic test_vectors;
    logic [15:0] ta [10];
    logic [15:0] tb [10];
    logic        te [10];
    logic [31:0] tr [10];
    int i;
    logic [32:0] e;
    ta = '{16'd1000, 16'd1000, 16'hFC18, 16'hFC18, 16'd5,
           16'd5, 16'd0, 16'd1234, 16'hFFFF, 16'h8000};
    tb = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd7,
           16'd7, 16'd1234, 16'd0, 16'd1, 16'h8000};
    te = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
           1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tr = '{32'd3024, 32'd3000, 32'hFFFFF42F, 32'hFFFFF448,
           32'd35, 32'd35, 32'd0, 32'd0, 32'hFFFFFFFF,
           32'd1040449536};
    i = 0; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (i < 10);
      if (i < 10) begin
        a = ta[i]; b = tb[i]; in_exact = te[i];
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back({te[i], tr[i]});
        i++;
      end
      if (out_valid && out_ready) begin
        n_run++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL vec_extra got %h want none", r);
        end else begin
          e = q.pop_front();
          if ({out_exact, r} !== e) begin
            n_fail++;
            $display("FAIL vec got %b/%h want %b/%h",
                     out_exact, r, e[32], e[31:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    a = 16'h8000; b = 16'h8000; in_exact = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c == 0);
      @(negedge clk);
      if (in_valid && in_ready)
        q.push_back({1'b1, 32'd1073741824});
      if (out_valid && out_ready) begin
        n_run++;
        e = q.pop_front();
        if ({out_exact, r} !== e) begin
          n_fail++;
          $display("FAIL vec_min_exact got %h want %h",
                   r, e[31:0]);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL vec_drain got %0d left want 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_back_to_back;
    int sent, run, best;
    logic [32:0] e;
    sent = 0; run = 0; best = 0; out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (sent < 8);
      a = 16'($urandom); b = 16'($urandom);
      in_exact = sent[0];
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back(f_model(a, b, in_exact));
        sent++;
      end
      if (out_valid) run++; else run = 0;
      if (run > best) best = run;
      if (out_valid && out_ready) begin
        n_run++;
        e = q.pop_front();
        if ({out_exact, r} !== e) begin
          n_fail++;
          $display("FAIL b2b got %b/%h want %b/%h",
                   out_exact, r, e[32], e[31:0]);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_run++;
    if (best !== 8) begin
      n_fail++;
      $display("FAIL b2b_run got %0d want 8", best);
    end
    q.delete();
  endtask

  task automatic test_backpressure;
    logic [32:0] e;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 8);
      out_ready = !(c >= 3 && c < 8);
      a = ($urandom_range(0, 3) == 0) ? 16'h8000
                                       : 16'($urandom);
      b = 16'($urandom);
      in_exact = 1'($urandom);
      @(negedge clk);
      if (c >= 3 && c < 8) begin
        n_run++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_in_ready got %b want 0", in_ready);
        end
        n_run++;
        if (q.size() == 0 || out_valid !== 1'b1
            || {out_exact, r} !== q[0]) begin
          n_fail++;
          $display("FAIL bp_hold got %b/%b/%h want 1/head",
                   out_valid, out_exact, r);
        end
      end
      if (in_valid && in_ready)
        q.push_back(f_model(a, b, in_exact));
      if (out_valid && out_ready) begin
        n_run++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_dup got %h want none", r);
        end else begin
          e = q.pop_front();
          if ({out_exact, r} !== e) begin
            n_fail++;
            $display("FAIL bp got %b/%h want %b/%h",
                     out_exact, r, e[32], e[31:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_lost got %0d left want 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_reset_flight;
    out_ready = 1'b0; in_exact = 1'b0;
    a = 16'd1000; b = 16'd3;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_run++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rf_full got %b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_run++;
    if (out_valid !== 1'b0 || r !== 32'h0) begin
      n_fail++;
      $display("FAIL rf_async got %b/%h want 0/0",
               out_valid, r);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_run++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rf_stale got %b want 0", out_valid);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [32:0] e;
    for (int c = 0; c < 240; c++) begin
      in_valid  = (c < 200) && ($urandom_range(0, 3) != 0);
      out_ready = (c >= 200) || ($urandom_range(0, 2) != 0);
      a = 16'($urandom); b = 16'($urandom);
      in_exact = 1'($urandom);
      @(negedge clk);
      if (in_valid && in_ready)
        q.push_back(f_model(a, b, in_exact));
      if (out_valid && out_ready) begin
        n_run++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra got %h want none", r);
        end else begin
          e = q.pop_front();
          if ({out_exact, r} !== e) begin
            n_fail++;
            $display("FAIL rnd got %b/%h want %b/%h",
                     out_exact, r, e[32], e[31:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_drain got %0d left want 0", q.size());
    end
    q.delete();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_flight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
